fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end directly upstream of the ID-stage decoder: drives the PC,
//  issues in-order requests on the sram-like inst port, and buffers returned words.
//  Presents {inst, pc, adel} to decode via a valid/ready handshake.
//  Flush (branch, jump or exception redirect) discards queued and in-flight words, then
//  restarts fetch at flush_pc.
// PARAMETERS
//  DEPTH     4             queue slots; also the max in-flight requests (power of 2, >=2)
//  RESET_PC  32'hbfc00000  first fetch address after reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  inst_req       out  1   fetch request
//  inst_addr      out  32  request address (= fetch_pc)
//  inst_addr_ok   in   1   request accepted this cycle
//  inst_data_ok   in   1   read data valid this cycle (responses return in request order)
//  inst_rdata     in   32  read data
//  flush          in   1   redirect pulse
//  flush_pc       in   32  redirect target
//  id_valid       out  1   head entry is complete and offered to decode
//  id_ready       in   1   decode accepts head
//  id_inst        out  32  head instruction (0 when id_adel)
//  id_pc          out  32  head PC
//  id_adel        out  1   head PC misaligned (fetch address error)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: fetch_pc=RESET_PC; all slots empty; pending=0; discard=0;
//    id_valid=0; inst_req=0 while rst is high.
//  - Storage: circular buffer of DEPTH slots {pc, inst, adel, filled}.
//    Pointers are alloc, fill and head.
//    - alloc_cnt = number of allocated slots, 0..DEPTH.
//    - pending = accepted requests whose data has not yet returned.
//  - Request rule, combinational:
//    - inst_req = !rst & !flush & fetch_pc[1:0]==0 & alloc_cnt<DEPTH & (pending+discard)<DEPTH.
//    - inst_addr=fetch_pc.
//  - Handshake (inst_req & inst_addr_ok):
//    - allocate slot at alloc with pc=fetch_pc and filled=0;
//    - fetch_pc += 4; pending++.
//    - Each slot is reserved at acceptance, so the queue cannot overflow.
//  - Response (inst_data_ok):
//    - if discard>0: drop the word and decrement discard;
//    - else: write inst to slot fill, set filled, advance fill, pending--.
//  - Misaligned fetch_pc (fetch_pc[1:0]!=0):
//    - no bus request is issued;
//    - once pending==0 and alloc_cnt<DEPTH, allocate one slot {pc, inst=0, adel=1, filled=1};
//    - fetch then halts, with fetch_pc held and no further allocation, until flush.
//  - Output: id_valid = slot[head].filled & !flush; id_* driven combinationally from slot[head].
//  - Pop (id_valid & id_ready): clear slot, advance head, alloc_cnt--.
//    Pop and allocate/fill may occur in the same cycle; the counters net correctly.
//  - Flush (highest priority, single cycle):
//    - all slots cleared and alloc_cnt=0;
//    - discard <= discard + pending, where pending includes the request handshaking this
//      cycle (inst_req is low, so none) minus any data_ok consumed this cycle;
//    - pending=0 and fetch_pc <= flush_pc;
//    - a data_ok in the flush cycle is dropped (it counts against the old pending/discard);
//    - a pop in the flush cycle is ignored.
//  - Counter widths: $clog2(DEPTH)+1 bits. The request rule bounds pending+discard<=DEPTH,
//    so no wrap-around occurs.
//  - Latency: a request accepted at cycle N with data_ok at N+k gives id_valid at N+k+1.
//    Queue bypass is not permitted.
//  - Reset mid-operation clears everything. Words still in flight are not tracked after reset;
//    the memory interface is reset simultaneously.
// TESTING
//  1. Reset, addr_ok=1, data_ok 1 cycle later, id_ready=1 -> addrs bfc00000, bfc00004, ...;
//     id_pc sequential; id_inst matches rdata in order.
//  2. id_ready=0, memory always ready -> exactly 4 requests accepted; inst_req then low;
//     after one pop, one new request.
//  3. Flush with 2 pending requests, flush_pc=80000180 -> next 2 data_ok words dropped;
//     first id_valid shows pc=80000180.
//  4. Flush coinciding with data_ok and a pop -> returned word dropped, discard=pending-1,
//     no pop; id_valid=0 that cycle.
//  5. flush_pc=bfc00002 -> no inst_req; one entry with id_adel=1, inst=0, pc=bfc00002;
//     fetch halts until the next flush.
//  6. Assert rst while 3 requests are pending -> next cycle id_valid=0, inst_addr=bfc00000,
//     inst_req=1.

Source files
------------

// File: rtl/fetch_queue_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch front-end signals: the sram-like
//               instruction port, the redirect (flush) inputs and the
//               valid/ready handshake towards the decoder.
//               master : fetch_queue side
//               slave  : memory + decode + redirect side
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if;
   // instruction memory port
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   // redirect
   logic        flush;
   logic [31:0] flush_pc;
   // decode handshake
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_adel;

   modport master (
      output inst_req, inst_addr, id_valid, id_inst, id_pc, id_adel,
      input  inst_addr_ok, inst_data_ok, inst_rdata, flush, flush_pc, id_ready
   );

   modport slave (
      input  inst_req, inst_addr, id_valid, id_inst, id_pc, id_adel,
      output inst_addr_ok, inst_data_ok, inst_rdata, flush, flush_pc, id_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end. Drives the PC, issues in-order
//               requests on the sram-like instruction port and buffers the
//               returned words in a circular queue whose slots are reserved
//               when a request is accepted. The head slot is offered to the
//               decoder once its data has arrived. A flush discards queued
//               and in-flight words and restarts fetch at flush_pc.
// Ports       : clk        clock
//               rst        synchronous active-high reset
//               bus.inst_* request/response port (master side)
//               bus.flush, bus.flush_pc  redirect pulse and target
//               bus.id_*   head entry {inst, pc, adel} with valid/ready
// Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input wire logic      clk,
   input wire logic      rst,
   fetch_queue_if.master bus
);

   localparam int                 c_ptr_w     = $clog2(DEPTH);
   localparam int                 c_cnt_w     = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   // ---------------------------------------------------------------- state
   logic [31:0]        fetch_pc_q,  fetch_pc_d;
   logic [c_ptr_w-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [c_ptr_w-1:0] fill_ptr_q,  fill_ptr_d;
   logic [c_ptr_w-1:0] head_ptr_q,  head_ptr_d;
   logic [c_cnt_w-1:0] alloc_cnt_q, alloc_cnt_d;
   logic [c_cnt_w-1:0] pending_q,   pending_d;
   logic [c_cnt_w-1:0] discard_q,   discard_d;
   logic               halted_q,    halted_d;

   logic [31:0]        slot_pc_q   [DEPTH];
   logic [31:0]        slot_pc_d   [DEPTH];
   logic [31:0]        slot_inst_q [DEPTH];
   logic [31:0]        slot_inst_d [DEPTH];
   logic [DEPTH-1:0]   slot_adel_q,   slot_adel_d;
   logic [DEPTH-1:0]   slot_filled_q, slot_filled_d;

   // ------------------------------------------------------- control terms
   logic               w_aligned;
   logic               w_room;
   logic [c_cnt_w:0]   w_outstanding;
   logic               w_credit;
   logic               w_req;
   logic               w_accept;
   logic               w_adel_alloc;
   logic               w_alloc;
   logic               w_fill;
   logic               w_drop;
   logic               w_id_valid;
   logic               w_pop;

   assign w_aligned     = (fetch_pc_q[1:0] == 2'b00);
   assign w_room        = (alloc_cnt_q < c_depth_cnt);
   // Words owed by memory, whether wanted or to be thrown away, must never
   // exceed the queue depth; this keeps every counter inside its width.
   assign w_outstanding = {1'b0, pending_q} + {1'b0, discard_q};
   assign w_credit      = (w_outstanding < {1'b0, c_depth_cnt});
   assign w_req         = !rst && !bus.flush && w_aligned && w_room && w_credit;
   assign w_accept      = w_req && bus.inst_addr_ok;
   // A misaligned PC produces a single error entry, and only after all older
   // requests have returned so the entry stays in program order.
   assign w_adel_alloc  = !bus.flush && !w_aligned && !halted_q &&
                          (pending_q == '0) && w_room;
   assign w_alloc       = w_accept || w_adel_alloc;
   assign w_drop        = bus.inst_data_ok && (discard_q != '0);
   assign w_fill        = bus.inst_data_ok && (discard_q == '0);
   assign w_id_valid    = slot_filled_q[head_ptr_q] && !bus.flush;
   assign w_pop         = w_id_valid && bus.id_ready;

   // -------------------------------------------------------------- outputs
   assign bus.inst_req  = w_req;
   assign bus.inst_addr = fetch_pc_q;
   assign bus.id_valid  = w_id_valid;
   assign bus.id_inst   = slot_inst_q[head_ptr_q];
   assign bus.id_pc     = slot_pc_q[head_ptr_q];
   assign bus.id_adel   = slot_adel_q[head_ptr_q];

   // ----------------------------------------------------------- next state
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      alloc_ptr_d   = alloc_ptr_q;
      fill_ptr_d    = fill_ptr_q;
      head_ptr_d    = head_ptr_q;
      alloc_cnt_d   = alloc_cnt_q;
      pending_d     = pending_q;
      discard_d     = discard_q;
      halted_d      = halted_q;
      slot_pc_d     = slot_pc_q;
      slot_inst_d   = slot_inst_q;
      slot_adel_d   = slot_adel_q;
      slot_filled_d = slot_filled_q;

      // Response: either an orphan from before a flush, or the next slot in
      // request order.
      if (w_drop) begin
         discard_d = discard_q - c_cnt_one;
      end
      if (w_fill) begin
         slot_inst_d[fill_ptr_q]   = bus.inst_rdata;
         slot_filled_d[fill_ptr_q] = 1'b1;
         fill_ptr_d                = fill_ptr_q + 1'b1;
      end

      // Allocation: a slot is reserved at request acceptance (data pending)
      // or for the misaligned-PC error entry (complete immediately).
      if (w_accept) begin
         slot_pc_d[alloc_ptr_q]     = fetch_pc_q;
         slot_inst_d[alloc_ptr_q]   = 32'h0;
         slot_adel_d[alloc_ptr_q]   = 1'b0;
         slot_filled_d[alloc_ptr_q] = 1'b0;
         alloc_ptr_d                = alloc_ptr_q + 1'b1;
         fetch_pc_d                 = fetch_pc_q + 32'd4;
      end else if (w_adel_alloc) begin
         slot_pc_d[alloc_ptr_q]     = fetch_pc_q;
         slot_inst_d[alloc_ptr_q]   = 32'h0;
         slot_adel_d[alloc_ptr_q]   = 1'b1;
         slot_filled_d[alloc_ptr_q] = 1'b1;
         alloc_ptr_d                = alloc_ptr_q + 1'b1;
         // no data will arrive for this slot, so the fill pointer skips it
         fill_ptr_d                 = fill_ptr_q + 1'b1;
         halted_d                   = 1'b1;
      end

      if (w_pop) begin
         slot_filled_d[head_ptr_q] = 1'b0;
         slot_adel_d[head_ptr_q]   = 1'b0;
         head_ptr_d                = head_ptr_q + 1'b1;
      end

      alloc_cnt_d = alloc_cnt_q + c_cnt_w'(w_alloc) - c_cnt_w'(w_pop);
      pending_d   = pending_q + c_cnt_w'(w_accept) - c_cnt_w'(w_fill);

      // Redirect overrides everything above. Every word still owed by memory
      // becomes an orphan; a word returning this very cycle has already paid
      // off one of them (from discard or pending, whichever it hit).
      if (bus.flush) begin
         slot_filled_d = '0;
         slot_adel_d   = '0;
         alloc_ptr_d   = '0;
         fill_ptr_d    = '0;
         head_ptr_d    = '0;
         alloc_cnt_d   = '0;
         discard_d     = discard_q + pending_q - c_cnt_w'(bus.inst_data_ok);
         pending_d     = '0;
         fetch_pc_d    = bus.flush_pc;
         halted_d      = 1'b0;
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         alloc_ptr_q   <= '0;
         fill_ptr_q    <= '0;
         head_ptr_q    <= '0;
         alloc_cnt_q   <= '0;
         pending_q     <= '0;
         discard_q     <= '0;
         halted_q      <= 1'b0;
         slot_adel_q   <= '0;
         slot_filled_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc_q[i]   <= 32'h0;
            slot_inst_q[i] <= 32'h0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         alloc_ptr_q   <= alloc_ptr_d;
         fill_ptr_q    <= fill_ptr_d;
         head_ptr_q    <= head_ptr_d;
         alloc_cnt_q   <= alloc_cnt_d;
         pending_q     <= pending_d;
         discard_q     <= discard_d;
         halted_q      <= halted_d;
         slot_adel_q   <= slot_adel_d;
         slot_filled_q <= slot_filled_d;
         slot_pc_q     <= slot_pc_d;
         slot_inst_q   <= slot_inst_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A queue-level model of
//               the fetch front end is compared with the DUT every cycle;
//               directed scenarios add hand-computed literal expectations.
//               The memory returns ~addr as read data.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int hs_cnt = 0;
   int cyc    = 0;
   bit done   = 1'b0;

   // memory knobs
   bit mem_hold = 1'b0;
   int mem_lat  = 1;

   typedef struct { logic [31:0] addr; int acc; } mreq_t;
   mreq_t mem_fifo[$];

   // model: ordered list of allocated entries plus a few counters
   typedef struct { logic [31:0] pc; logic [31:0] inst; bit adel; bit filled; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc;
   int          m_pend;
   int          m_disc;
   bit          m_halt;

   bit   e_req, e_valid, do_pop, do_acc, do_adel, found;
   ent_t tmp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- memory
   initial begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (!mem_hold && mem_fifo.size() > 0 && cyc >= mem_fifo[0].acc + mem_lat) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = ~mem_fifo[0].addr;
            void'(mem_fifo.pop_front());
         end else begin
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = 32'h0;
         end
      end
   end

   // ------------------------------------------- compare + model, per cycle
   always @(negedge clk) begin
      if (!done) begin
         e_req   = !rst && !bus.flush && (m_pc[1:0] == 2'b00) &&
                   (m_q.size() < DEPTH) && (m_pend + m_disc < DEPTH);
         e_valid = !bus.flush && (m_q.size() > 0) && m_q[0].filled;

         check("inst_req", {31'b0, bus.inst_req}, {31'b0, e_req});
         if (!rst) begin
            check("inst_addr", bus.inst_addr, m_pc);
            check("id_valid", {31'b0, bus.id_valid}, {31'b0, e_valid});
            if (e_valid) begin
               check("id_pc",   bus.id_pc,   m_q[0].pc);
               check("id_inst", bus.id_inst, m_q[0].inst);
               check("id_adel", {31'b0, bus.id_adel}, {31'b0, m_q[0].adel});
            end
         end

         // memory sees what the DUT actually requested
         if (rst) begin
            mem_fifo.delete();
         end else if (bus.inst_req && bus.inst_addr_ok) begin
            mem_fifo.push_back('{addr: bus.inst_addr, acc: cyc});
            hs_cnt++;
         end

         // advance the model to the state after the coming clock edge
         if (rst) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_pend = 0;
            m_disc = 0;
            m_halt = 1'b0;
         end else if (bus.flush) begin
            if (bus.inst_data_ok) begin
               if (m_disc > 0) m_disc--;
               else if (m_pend > 0) m_pend--;
            end
            m_disc = m_disc + m_pend;
            m_pend = 0;
            m_q.delete();
            m_pc   = bus.flush_pc;
            m_halt = 1'b0;
         end else begin
            do_pop  = e_valid && bus.id_ready;
            do_acc  = e_req && bus.inst_addr_ok;
            do_adel = (m_pc[1:0] != 2'b00) && !m_halt && (m_pend == 0) && (m_q.size() < DEPTH);
            if (do_pop) void'(m_q.pop_front());
            if (bus.inst_data_ok) begin
               if (m_disc > 0) begin
                  m_disc--;
               end else begin
                  found = 1'b0;
                  for (int i = 0; i < m_q.size(); i++) begin
                     if (!found && !m_q[i].filled) begin
                        tmp        = m_q[i];
                        tmp.inst   = bus.inst_rdata;
                        tmp.filled = 1'b1;
                        m_q[i]     = tmp;
                        found      = 1'b1;
                     end
                  end
                  if (m_pend > 0) m_pend--;
               end
            end
            if (do_acc) begin
               m_q.push_back('{pc: m_pc, inst: 32'h0, adel: 1'b0, filled: 1'b0});
               m_pc = m_pc + 32'd4;
               m_pend++;
            end else if (do_adel) begin
               m_q.push_back('{pc: m_pc, inst: 32'h0, adel: 1'b1, filled: 1'b1});
               m_halt = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.flush = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ends at a negedge where id_valid is high (or counts a failure)
   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.id_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!bus.id_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: id_valid not seen within %0d cycles, got 0 expected 1", name, budget);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      rst              = 1'b1;
      bus.flush        = 1'b0;
      bus.flush_pc     = 32'h0;
      bus.id_ready     = 1'b0;
      bus.inst_addr_ok = 1'b0;

      // 1: streaming fetch, one-cycle memory, decoder always ready
      bus.id_ready = 1'b1; bus.inst_addr_ok = 1'b1; mem_hold = 1'b0; mem_lat = 1;
      do_reset();
      @(negedge clk);
      check("t1_rst_valid", {31'b0, bus.id_valid}, 32'h0);
      check("t1_rst_req",   {31'b0, bus.inst_req}, 32'h1);
      check("t1_rst_addr",  bus.inst_addr, 32'hbfc00000);
      wait_valid("t1_first", 10);
      check("t1_pc0",   bus.id_pc,   32'hbfc00000);
      check("t1_inst0", bus.id_inst, 32'h403fffff);
      @(negedge clk);
      check("t1_pc1",   bus.id_pc,   32'hbfc00004);
      check("t1_inst1", bus.id_inst, 32'h403ffffb);
      repeat (8) tick();

      // 2: decoder stalled -> queue fills after 4 accepts, one pop frees one
      bus.id_ready = 1'b0;
      do_reset();
      hs_cnt = 0;
      repeat (10) tick();
      @(negedge clk);
      check("t2_accepts", hs_cnt, 32'd4);
      check("t2_req_low", {31'b0, bus.inst_req}, 32'h0);
      check("t2_head_pc", bus.id_pc, 32'hbfc00000);
      tick();
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      check("t2_accepts_after_pop", hs_cnt, 32'd5);
      check("t2_req_low2", {31'b0, bus.inst_req}, 32'h0);
      check("t2_head_pc2", bus.id_pc, 32'hbfc00004);
      tick();

      // 3: flush with two requests in flight
      bus.id_ready = 1'b1; mem_hold = 1'b1; bus.inst_addr_ok = 1'b1;
      do_reset();
      tick();
      tick();
      bus.inst_addr_ok = 1'b0;
      tick();
      bus.flush = 1'b1; bus.flush_pc = 32'h80000180; bus.inst_addr_ok = 1'b1;
      @(negedge clk);
      check("t3_flush_req",   {31'b0, bus.inst_req}, 32'h0);
      check("t3_flush_valid", {31'b0, bus.id_valid}, 32'h0);
      tick();
      bus.flush = 1'b0; mem_hold = 1'b0;
      @(negedge clk);
      check("t3_new_addr", bus.inst_addr, 32'h80000180);
      wait_valid("t3_first", 20);
      check("t3_pc",   bus.id_pc,   32'h80000180);
      check("t3_inst", bus.id_inst, 32'h7ffffe7f);
      tick();

      // 4: flush coinciding with a returning word and a pop attempt
      bus.id_ready = 1'b0; mem_lat = 2; bus.inst_addr_ok = 1'b1;
      do_reset();
      tick();
      tick();
      tick();
      bus.flush = 1'b1; bus.flush_pc = 32'h00001000; bus.id_ready = 1'b1;
      @(negedge clk);
      check("t4_flush_valid", {31'b0, bus.id_valid}, 32'h0);
      check("t4_flush_req",   {31'b0, bus.inst_req}, 32'h0);
      tick();
      bus.flush = 1'b0;
      wait_valid("t4_first", 20);
      check("t4_pc",   bus.id_pc,   32'h00001000);
      check("t4_inst", bus.id_inst, 32'hffffefff);
      check("t4_adel", {31'b0, bus.id_adel}, 32'h0);
      tick();

      // 5: misaligned redirect -> single error entry, fetch halts
      bus.id_ready = 1'b0; mem_lat = 1; bus.inst_addr_ok = 1'b1;
      do_reset();
      tick();
      tick();
      bus.flush = 1'b1; bus.flush_pc = 32'hbfc00002;
      tick();
      bus.flush = 1'b0;
      hs_cnt = 0;
      wait_valid("t5_adel", 10);
      check("t5_pc",   bus.id_pc,   32'hbfc00002);
      check("t5_adel", {31'b0, bus.id_adel}, 32'h1);
      check("t5_inst", bus.id_inst, 32'h0);
      tick();
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      check("t5_no_accepts", hs_cnt, 32'd0);
      check("t5_halt_valid", {31'b0, bus.id_valid}, 32'h0);
      check("t5_halt_req",   {31'b0, bus.inst_req}, 32'h0);
      check("t5_halt_addr",  bus.inst_addr, 32'hbfc00002);
      tick();
      bus.flush = 1'b1; bus.flush_pc = 32'h80000000;
      tick();
      bus.flush = 1'b0;
      wait_valid("t5_resume", 10);
      check("t5_resume_pc",   bus.id_pc,   32'h80000000);
      check("t5_resume_inst", bus.id_inst, 32'h7fffffff);
      tick();

      // 6: reset while three requests are in flight
      bus.id_ready = 1'b1; mem_hold = 1'b1; bus.inst_addr_ok = 1'b1;
      do_reset();
      tick();
      tick();
      tick();
      bus.inst_addr_ok = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_req", {31'b0, bus.inst_req}, 32'h0);
      tick();
      rst = 1'b0; bus.inst_addr_ok = 1'b1; mem_hold = 1'b0;
      @(negedge clk);
      check("t6_valid", {31'b0, bus.id_valid}, 32'h0);
      check("t6_addr",  bus.inst_addr, 32'hbfc00000);
      check("t6_req",   {31'b0, bus.inst_req}, 32'h1);
      wait_valid("t6_first", 10);
      check("t6_pc",   bus.id_pc,   32'hbfc00000);
      check("t6_inst", bus.id_inst, 32'h403fffff);
      repeat (3) tick();

      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
